// File: rtl/transmissor_paridade.sv
// Serial parity transmitter: frames b1..b5 plus parity bit bp as start/data/parity/stop on tx.
// Define PARIDADE_IMPAR_EN for odd parity; the default build uses even parity.
module transmissor_paridade #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  input  logic b4,
  input  logic b5,
  output logic tx,
  output logic busy,
  output logic done,
  output logic p_b1,
  output logic p_b2,
  output logic p_b3,
  output logic p_b4,
  output logic p_b5,
  output logic p_bp
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [4:0]    shreg;
  logic          par_in;
  logic          bit_end;

  always_comb begin
`ifdef PARIDADE_IMPAR_EN
    par_in = ~(b1 ^ b2 ^ b3 ^ b4 ^ b5);
`else
    par_in = b1 ^ b2 ^ b3 ^ b4 ^ b5;
`endif
    bit_end = (cnt == '0);
  end

  // NOTE: all state and outputs use non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tx    <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      p_b1  <= 1'b0;
      p_b2  <= 1'b0;
      p_b3  <= 1'b0;
      p_b4  <= 1'b0;
      p_b5  <= 1'b0;
      p_bp  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= START;
            tx    <= 1'b0;
            busy  <= 1'b1;
            cnt   <= RELOAD;
            idx   <= '0;
            shreg <= {b5, b4, b3, b2, b1};
            p_b1  <= b1;
            p_b2  <= b2;
            p_b3  <= b3;
            p_b4  <= b4;
            p_b5  <= b5;
            p_bp  <= par_in;
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            tx    <= shreg[0];
            shreg <= shreg >> 1;
            cnt   <= RELOAD;
            idx   <= '0;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= RELOAD;
            if (idx == 3'd4) begin
              state <= PARITY;
              tx    <= p_bp;
            end else begin
              idx   <= idx + 3'd1;
              tx    <= shreg[0];
              shreg <= shreg >> 1;
            end
          end else begin
            cnt <= cnt - ONE;
          end
        end
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            tx    <= 1'b1;
            cnt   <= RELOAD;
            // done is registered, so it must be raised one edge ahead of the last stop cycle
            done  <= (CLKS_PER_BIT == 1);
          end else begin
            cnt <= cnt - ONE;
          end
        end
        STOP: begin
          if (bit_end) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt  <= cnt - ONE;
            done <= (cnt == ONE);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_transmissor_paridade.sv
// Scoreboard bench for transmissor_paridade: one instance with CLKS_PER_BIT=1, one with 4.
module tb_transmissor_paridade;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0;
  logic start4 = 1'b0;
  logic b1 = 1'b0, b2 = 1'b0, b3 = 1'b0, b4 = 1'b0, b5 = 1'b0;

  logic tx1, busy1, done1, pb1_1, pb2_1, pb3_1, pb4_1, pb5_1, pbp_1;
  logic tx4, busy4, done4, pb1_4, pb2_4, pb3_4, pb4_4, pb5_4, pbp_4;
  logic [5:0] p1, p4;

  assign p1 = {pb1_1, pb2_1, pb3_1, pb4_1, pb5_1, pbp_1};
  assign p4 = {pb1_4, pb2_4, pb3_4, pb4_4, pb5_4, pbp_4};

  transmissor_paridade #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5),
    .tx(tx1), .busy(busy1), .done(done1),
    .p_b1(pb1_1), .p_b2(pb2_1), .p_b3(pb3_1), .p_b4(pb4_1), .p_b5(pb5_1), .p_bp(pbp_1)
  );

  transmissor_paridade #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5),
    .tx(tx4), .busy(busy4), .done(done4),
    .p_b1(pb1_4), .p_b2(pb2_4), .p_b3(pb3_4), .p_b4(pb4_4), .p_b5(pb5_4), .p_bp(pbp_4)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       tx;
    logic       done;
    logic       first;
    logic [5:0] pw;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef PARIDADE_IMPAR_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // w[0] is b1; expected serial frame is start, b1..b5, parity, stop
  task automatic push_frame(input int which, input logic [4:0] w, input int cpb);
    logic       par;
    logic [7:0] seq;
    exp_t       e;
    par = (^w) ^ ODD;
    seq = {1'b1, par, w[4], w[3], w[2], w[1], w[0], 1'b0};
    for (int b = 0; b < 8; b++) begin
      for (int c = 0; c < cpb; c++) begin
        e.tx    = seq[b];
        e.done  = (b == 7) && (c == cpb - 1);
        e.first = (b == 0) && (c == 0);
        e.pw    = {w[0], w[1], w[2], w[3], w[4], par};
        if (which == 1) q1.push_back(e);
        else            q4.push_back(e);
      end
    end
  endtask

  task automatic send(input int which, input logic [4:0] w);
    @(negedge clk);
    {b5, b4, b3, b2, b1} = w;
    if (which == 1) start1 = 1'b1;
    else            start4 = 1'b1;
    push_frame(which, w, (which == 1) ? 1 : 4);
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
    check("busy_after_accept", (which == 1) ? busy1 : busy4, 1'b1);
  endtask

  task automatic wait_done(input int which);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = (which == 1) ? done1 : done4;
    end
    if (!seen) check("done_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("queue_drained", (which == 1) ? q1.size() : q4.size(), 0);
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst) begin
      if (busy1) begin
        if (q1.size() == 0) begin
          check("dut1_extra_busy", 1'b1, 1'b0);
        end else begin
          e = q1.pop_front();
          check("dut1_tx", tx1, e.tx);
          check("dut1_done", done1, e.done);
          if (e.first) check("dut1_pword", p1, e.pw);
        end
      end else begin
        check("dut1_idle_tx", tx1, 1'b1);
        check("dut1_idle_done", done1, 1'b0);
      end
    end
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (!rst) begin
      if (busy4) begin
        if (q4.size() == 0) begin
          check("dut4_extra_busy", 1'b1, 1'b0);
        end else begin
          e = q4.pop_front();
          check("dut4_tx", tx4, e.tx);
          check("dut4_done", done4, e.done);
          if (e.first) check("dut4_pword", p4, e.pw);
        end
      end else begin
        check("dut4_idle_tx", tx4, 1'b1);
        check("dut4_idle_done", done4, 1'b0);
      end
    end
  end

  initial begin
    // Reset held for two cycles
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx1", tx1, 1'b1);
    check("rst_busy1", busy1, 1'b0);
    check("rst_done1", done1, 1'b0);
    check("rst_p1", p1, 6'b0);
    check("rst_tx4", tx4, 1'b1);
    check("rst_busy4", busy4, 1'b0);
    check("rst_p4", p4, 6'b0);
    rst = 1'b0;

    // b1..b5 = 1,0,1,1,0 -> tx 0,1,0,1,1,0,p,1 ; even parity 1, odd parity 0
    send(1, 5'b01101);
    wait_done(1);
    check("p_bp_10110", pbp_1, ODD ? 1'b0 : 1'b1);

    // All-zero word, then a back-to-back frame with an ignored mid-frame start
    send(1, 5'b00000);
    wait_done(1);
    check("p_bp_00000", pbp_1, ODD ? 1'b1 : 1'b0);
    send(1, 5'b10011);
    repeat (2) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done(1);
    repeat (3) @(negedge clk);
    check("ignored_start_idle", busy1, 1'b0);

    // Sweep every data word back-to-back
    for (int w = 0; w < 32; w++) begin
      send(1, 5'(w));
      wait_done(1);
    end

    // Slow instance: each bit held 4 cycles, 32 busy cycles
    send(4, 5'b11111);
    wait_done(4);
    check("p_bp_11111_cpb4", pbp_4, ODD ? 1'b0 : 1'b1);

    // Reset mid-frame truncates without done
    send(1, 5'b01101);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", tx1, 1'b1);
    check("midrst_busy", busy1, 1'b0);
    check("midrst_done", done1, 1'b0);
    check("midrst_p", p1, 6'b0);
    q1.delete();
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Recovery after truncation
    send(1, 5'b00110);
    wait_done(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
